rgb_led_arbiter: RTL and testbench
==================================

# rgb_led_arbiter

Shares the board's single tri-colour LED between two requesters, for example the PyRTL calculator core and a status/heartbeat source. It runs a round-robin arbiter with a minimum ownership time, and latches the owner's 3-channel colour request. It produces glitch-free PWM gate signals that feed the red, green and blue PWM inputs of the iCE40 SB_RGBA_DRV hard macro in the top-level wrapper.

## Interface
Parameters:
- PWM_BITS, 8, width of each colour duty value and of the PWM period counter (period = 2^PWM_BITS cycles).
- HOLD_CYCLES, 4096, minimum number of cycles a granted requester keeps the LED before it can be pre-empted by the other requester; must be ≥ 1.

Ports:
- clk  in  1  system clock (48 MHz after the global buffer); the block uses one clock.
- rst  in  1  reset, synchronous and active-high.
- req_i  in  2  per-requester request; bit 0 = requester 0, bit 1 = requester 1.
- color0_i  in  3*PWM_BITS  requester 0 duty values, packed {blue, green, red}.
- color1_i  in  3*PWM_BITS  requester 1 duty values, same packing.
- gnt_o  out  2  one-hot grant (or 0 when idle), registered.
- red_o  out  1  red PWM gate, registered.
- green_o  out  1  green PWM gate, registered.
- blue_o  out  1  blue PWM gate, registered.
- period_start_o  out  1  one-cycle pulse when the PWM counter wraps to 0.

## Operation
- Arbiter FSM with three states: IDLE, OWN0 and OWN1.
  - IDLE: if any req is set, grant it. If both are set, grant the requester after last_owner (round-robin); last_owner resets to 1, so requester 0 wins first.
  - OWNn, owner drops req: the next cycle moves to the other requester if it is requesting, otherwise to IDLE.
  - OWNn, owner holds req, hold counter < HOLD_CYCLES-1: stay in OWNn.
  - OWNn, owner holds req, hold counter reached, other requester requesting: switch to OWN(other).
  - OWNn, owner holds req, hold counter reached, other requester not requesting: stay in OWNn.
  - The hold counter clears on every grant change and saturates at HOLD_CYCLES-1.
- Shadow duty register:
  - In OWNn, it loads colorN_i every cycle.
  - In IDLE, it loads 0.
- Active duty register:
  - It copies the shadow only when the PWM counter equals 2^PWM_BITS-1.
  - Every PWM period therefore uses a single, consistent duty set, with no mid-period glitch.
- PWM:
  - A free-running PWM_BITS counter.
  - Each channel output is (cnt < active_duty).
  - Duty 0 means constantly off; duty 2^PWM_BITS-1 means on for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
  - Unsigned compare; no overflow is possible.
- Simultaneous events:
  - Owner release and other request in the same cycle: direct hand-over, with no IDLE cycle.
  - Both requests rising together from IDLE: round-robin decides.

## Timing
- Reset values: gnt_o=0, red_o/green_o/blue_o=0, period_start_o=0, cnt=0, hold=0, shadow=active=0, state=IDLE, last_owner=1.
- Reset asserted mid-operation forces all of the above on the next edge, whatever the FSM state or PWM phase.
- Grant latency: req rising in IDLE gives gnt_o on the next edge (1 cycle).
- Colour-to-LED latency:
  - The shadow updates the cycle after gnt_o.
  - The active duty takes effect at the next wrap, so worst case is 2^PWM_BITS+2 cycles.
- period_start_o is high in the cycle where cnt==0.
- The first period after reset starts at the cycle in which rst is released.
- PWM outputs are registered: the output in cycle t reflects the compare of cnt in cycle t-1.

## Structure
- Package rgb_led_pkg holds:
  - the arbiter state enum (IDLE, OWN0, OWN1);
  - the default PWM_BITS;
  - the colour field offsets (RED=0, GREEN=1, BLUE=2).
- Sub-module rgb_pwm_channel, instantiated three times:
  - inputs: cnt, wrap strobe, shadow duty;
  - contents: active duty register and registered compare output.
- The arbiter FSM, hold counter and PWM counter live in rgb_led_arbiter.

## Test plan
Scenarios 2-5 use PWM_BITS=8 unless stated; scenario 2 uses HOLD_CYCLES=16.
- Reset, then req_i=0 for 600 cycles → gnt_o=0 and all LEDs 0; period_start_o pulses every 256 cycles.
- Both req set together from IDLE, then held:
  - gnt_o=01 after 1 cycle;
  - switches to 10 after exactly 16 cycles of ownership;
  - switches back after a further 16.
- req0 only, color0={0x00,0x80,0x40}:
  - after the next wrap, red is high for 64 of 256 cycles;
  - green is high for 128 of 256 cycles;
  - blue stays 0.
- Change color0_i mid-period → the duty of the current period is unchanged; the new duty applies from the cycle after period_start_o.
- Owner drops req in the same cycle the other raises req → gnt_o hands over directly (01→10) with no 00 cycle.
- Duty 0xFF → high for 255 of 256 cycles; rst pulsed mid-period → all outputs 0 the next cycle and cnt restarts at 0.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared types and constants for the RGB LED arbiter
//
// Purpose : arbiter state encoding, default PWM width and colour field offsets
//           within the packed {blue, green, red} duty word.
// Ports   : none (package).

package rgb_led_pkg;

  localparam int PWM_BITS_DEFAULT = 8;

  // Field index within a packed {blue, green, red} colour word
  localparam int COLOR_RED   = 0;
  localparam int COLOR_GREEN = 1;
  localparam int COLOR_BLUE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - one PWM colour channel with period-aligned duty update
//
// Purpose : holds the active duty for the current PWM period and produces the
//           registered gate (cnt < active duty).
// Ports   : clk     - system clock
//           rst     - synchronous active-high reset
//           i_cnt   - shared free-running PWM counter
//           i_wrap  - high in the last cycle of the period (cnt == max)
//           i_duty  - shadow duty from the arbiter
//           o_pwm   - registered PWM gate

module rgb_pwm_channel
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic                i_wrap,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_active;
  logic                r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      // Only latch a new duty at the period boundary so a period never mixes
      // two duty values.
      if (i_wrap) begin
        r_active <= i_duty;
      end
      r_pwm <= (i_cnt < r_active);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_led_arbiter.sv
// rtl/rgb_led_arbiter.sv - round-robin owner arbitration and PWM drive for one RGB LED
//
// Purpose : arbitrates the LED between two requesters with a minimum ownership
//           time, shadows the owner's colour and drives three PWM gates.
// Ports   : clk            - system clock
//           rst            - synchronous active-high reset
//           req_i[1:0]     - per-requester request
//           color0_i       - requester 0 duty, packed {blue, green, red}
//           color1_i       - requester 1 duty, same packing
//           gnt_o[1:0]     - one-hot grant, 0 when idle
//           red_o/green_o/blue_o - registered PWM gates
//           period_start_o - high in the cycle where the PWM counter is 0 after a wrap

module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEFAULT,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [3*PWM_BITS-1:0] color0_i,
  input  logic [3*PWM_BITS-1:0] color1_i,
  output logic [1:0]            gnt_o,
  output logic                  red_o,
  output logic                  green_o,
  output logic                  blue_o,
  output logic                  period_start_o
);

  localparam int                  HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  logic                  r_last_owner;
  logic [HOLD_W-1:0]     r_hold;
  logic                  w_hold_done;
  logic [PWM_BITS-1:0]   r_cnt;
  logic                  w_wrap;
  logic                  r_period_start;
  logic [3*PWM_BITS-1:0] r_shadow;

  assign w_hold_done = (r_hold == HOLD_MAX);
  assign w_wrap      = (r_cnt == CNT_MAX);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // Both requesting: the one after the previous owner wins.
        if (req_i[0] && req_i[1]) begin
          w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
        end else if (req_i[0]) begin
          w_next_state = ST_OWN0;
        end else if (req_i[1]) begin
          w_next_state = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!req_i[0]) begin
          w_next_state = req_i[1] ? ST_OWN1 : ST_IDLE;
        end else if (w_hold_done && req_i[1]) begin
          w_next_state = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req_i[1]) begin
          w_next_state = req_i[0] ? ST_OWN0 : ST_IDLE;
        end else if (w_hold_done && req_i[0]) begin
          w_next_state = ST_OWN0;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_last_owner   <= 1'b1;
      r_hold         <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
      r_shadow       <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_next_state == ST_OWN0) begin
        r_last_owner <= 1'b0;
      end else if (w_next_state == ST_OWN1) begin
        r_last_owner <= 1'b1;
      end

      // Hold counts cycles of the current grant; it restarts on every grant
      // change and sticks at its maximum once the minimum time has elapsed.
      if ((w_next_state != r_state) || (w_next_state == ST_IDLE)) begin
        r_hold <= '0;
      end else if (!w_hold_done) begin
        r_hold <= r_hold + 1'b1;
      end

      r_cnt          <= r_cnt + 1'b1;
      r_period_start <= w_wrap;

      case (r_state)
        ST_OWN0: r_shadow <= color0_i;
        ST_OWN1: r_shadow <= color1_i;
        default: r_shadow <= '0;
      endcase
    end
  end

  assign gnt_o          = {r_state == ST_OWN1, r_state == ST_OWN0};
  assign period_start_o = r_period_start;

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk    (clk),
    .rst    (rst),
    .i_cnt  (r_cnt),
    .i_wrap (w_wrap),
    .i_duty (r_shadow[COLOR_RED*PWM_BITS +: PWM_BITS]),
    .o_pwm  (red_o)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk    (clk),
    .rst    (rst),
    .i_cnt  (r_cnt),
    .i_wrap (w_wrap),
    .i_duty (r_shadow[COLOR_GREEN*PWM_BITS +: PWM_BITS]),
    .o_pwm  (green_o)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk    (clk),
    .rst    (rst),
    .i_cnt  (r_cnt),
    .i_wrap (w_wrap),
    .i_duty (r_shadow[COLOR_BLUE*PWM_BITS +: PWM_BITS]),
    .o_pwm  (blue_o)
  );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb/tb_rgb_led_arbiter.sv - self-checking bench for rgb_led_arbiter

module tb_rgb_led_arbiter;

  localparam int PWM_BITS    = 8;
  localparam int HOLD_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [23:0] color0_i;
  logic [23:0] color1_i;
  logic [1:0]  gnt_o;
  logic        red_o;
  logic        green_o;
  logic        blue_o;
  logic        period_start_o;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [1:0] req;
    int         n;
    logic [1:0] gnt;
  } vec_t;

  vec_t       tbl[17];
  logic [1:0] sb[$];

  rgb_led_arbiter #(
    .PWM_BITS    (PWM_BITS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .color0_i       (color0_i),
    .color1_i       (color1_i),
    .gnt_o          (gnt_o),
    .red_o          (red_o),
    .green_o        (green_o),
    .blue_o         (blue_o),
    .period_start_o (period_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [1:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got output with empty scoreboard, expected an entry", name);
    end else begin
      e = sb.pop_front();
      check(name, {30'b0, gnt_o}, {30'b0, e});
    end
  endtask

  // Each row drives req for n cycles; the expected grant is queued when the
  // stimulus is applied and compared one edge later.
  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        req_i = tbl[i].req;
        sb.push_back(tbl[i].gnt);
        @(negedge clk);
        pop_check($sformatf("gnt_row%0d_cyc%0d", i, r));
      end
    end
  endtask

  task automatic wait_ps(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start_o && n < max);
  endtask

  // Starts at a negedge where period_start_o is high; samples one full period.
  // Sample j reflects the compare of counter value j against the active duty.
  task automatic measure(input string tag, input int chg_at, input logic [23:0] chg_col,
                         input logic [23:0] exp_col);
    int         hi[3];
    int         first_lo[3];
    logic [2:0] b;
    logic [7:0] d;
    hi       = '{0, 0, 0};
    first_lo = '{256, 256, 256};
    for (int j = 0; j < 256; j++) begin
      if (j == chg_at) color0_i = chg_col;
      @(negedge clk);
      b = {blue_o, green_o, red_o};
      for (int c = 0; c < 3; c++) begin
        if (b[c]) hi[c]++;
        else if (first_lo[c] == 256) first_lo[c] = j;
      end
    end
    for (int c = 0; c < 3; c++) begin
      d = exp_col[c*8 +: 8];
      check($sformatf("%s_ch%0d_high_count", tag, c), hi[c], {24'b0, d});
      check($sformatf("%s_ch%0d_first_low", tag, c), first_lo[c], {24'b0, d});
    end
    check($sformatf("%s_wrap_aligned", tag), {31'b0, period_start_o}, 32'd1);
  endtask

  initial begin
    int n;
    int ps_cnt;
    int ps_first;
    int ps_second;
    int led_hi;
    int gnt_hi;

    n_checks = 0;
    n_errors = 0;

    tbl[0]  = '{2'b11, 16, 2'b01};
    tbl[1]  = '{2'b11, 16, 2'b10};
    tbl[2]  = '{2'b11, 16, 2'b01};
    tbl[3]  = '{2'b00,  1, 2'b00};
    tbl[4]  = '{2'b01, 20, 2'b01};
    tbl[5]  = '{2'b11,  1, 2'b10};
    tbl[6]  = '{2'b00,  1, 2'b00};
    tbl[7]  = '{2'b01,  5, 2'b01};
    tbl[8]  = '{2'b10,  4, 2'b10};
    tbl[9]  = '{2'b01,  1, 2'b01};
    tbl[10] = '{2'b00,  1, 2'b00};
    tbl[11] = '{2'b11,  1, 2'b10};
    tbl[12] = '{2'b00,  1, 2'b00};
    tbl[13] = '{2'b11,  1, 2'b01};
    tbl[14] = '{2'b00,  1, 2'b00};
    tbl[15] = '{2'b11,  1, 2'b01};
    tbl[16] = '{2'b00,  1, 2'b00};

    rst      = 1'b1;
    req_i    = 2'b00;
    color0_i = 24'h0;
    color1_i = 24'h0;
    repeat (3) @(negedge clk);
    check("reset_gnt", {30'b0, gnt_o}, 32'd0);
    check("reset_leds", {29'b0, blue_o, green_o, red_o}, 32'd0);
    check("reset_period_start", {31'b0, period_start_o}, 32'd0);

    // Idle run: counter is 0 in the release cycle, so pulses land 256 apart.
    rst       = 1'b0;
    ps_cnt    = 0;
    ps_first  = -1;
    ps_second = -1;
    led_hi    = 0;
    gnt_hi    = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (period_start_o) begin
        ps_cnt++;
        if (ps_first < 0) ps_first = k;
        else if (ps_second < 0) ps_second = k;
      end
      if (red_o || green_o || blue_o) led_hi++;
      if (gnt_o != 2'b00) gnt_hi++;
    end
    check("idle_ps_count", ps_cnt, 32'd2);
    check("idle_ps_first", ps_first, 32'd256);
    check("idle_ps_second", ps_second, 32'd512);
    check("idle_led_cycles", led_hi, 32'd0);
    check("idle_gnt_cycles", gnt_hi, 32'd0);

    apply_rows(0, 14);

    // PWM duty: red 0x40, green 0x80, blue 0x00.
    req_i    = 2'b01;
    color0_i = 24'h008040;
    wait_ps(300, n);
    check("pwm_sync1", {31'b0, period_start_o}, 32'd1);
    wait_ps(300, n);
    check("pwm_sync2", {31'b0, period_start_o}, 32'd1);
    measure("duty_a", -1, 24'h0, 24'h008040);
    measure("duty_b", 100, 24'h1020C0, 24'h008040);
    measure("duty_c", 50, 24'h0000FF, 24'h1020C0);
    measure("duty_d", -1, 24'h0, 24'h0000FF);

    // Reset mid-period while red is high.
    repeat (77) @(negedge clk);
    check("pre_rst_red", {31'b0, red_o}, 32'd1);
    rst   = 1'b1;
    req_i = 2'b00;
    @(negedge clk);
    check("midrst_gnt", {30'b0, gnt_o}, 32'd0);
    check("midrst_leds", {29'b0, blue_o, green_o, red_o}, 32'd0);
    check("midrst_period_start", {31'b0, period_start_o}, 32'd0);
    rst = 1'b0;
    wait_ps(400, n);
    check("midrst_cnt_restart", n, 32'd256);

    // last_owner returns to 1 after reset, so requester 0 wins the tie.
    apply_rows(15, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
